quad_step_decoder: RTL and testbench

//  Quadrature front end for the up/down counter. Synchronises and glitch-filters
//  raw A/B phase inputs and decodes phase transitions into a one-cycle step

---
 rtl/quad_pkg.sv | 29 ++
 rtl/phase_filter.sv | 47 ++++
 rtl/quad_step_decoder.sv | 82 ++++++++
 tb/tb_quad_step_decoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared constants and phase helper for the quadrature step decoder
// Purpose: default filter length, phase encodings {a,b}, direction codes and
//          the forward (up) Gray sequence used by the decoder.
// Ports:   none (package)
package quad_pkg;

  localparam int FILT_LEN_DEFAULT = 3;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Phase that follows ph when rotating in the up direction.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/phase_filter.sv
// rtl/phase_filter.sv - two-flop synchroniser plus persistence glitch filter for one phase
// Purpose: brings an asynchronous phase input into the clk domain and only lets
//          the filtered value follow after FILT_LEN consecutive differing cycles.
// Ports:
//   clk   in  1  clock
//   reset in  1  synchronous active-high reset; filtered value tracks x_s
//   x_in  in  1  raw asynchronous phase input
//   x_s   out 1  synchronised input (second sync flop)
//   x_f   out 1  filtered phase
module phase_filter #(
  parameter int FILT_LEN = quad_pkg::FILT_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic x_in,
  output logic x_s,
  output logic x_f
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          x_s1;
  logic [CW-1:0] cnt;

  // Sync chain runs regardless of reset so the tracked value is valid on release.
  always_ff @(posedge clk) begin
    x_s1 <= x_in;
    x_s  <= x_s1;
  end

  // cnt holds the number of earlier consecutive differing cycles; the current
  // differing cycle is the FILT_LEN-th when cnt reaches FILT_LEN-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      x_f <= x_s;
    end else if (x_s == x_f) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      cnt <= '0;
      x_f <= x_s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature front end producing step/dir pulses and a sticky error
// Purpose: filters A/B phases and decodes each filtered phase change into a
//          one-cycle step with direction; a simultaneous change of both phases
//          sets a sticky error instead.
// Ports:
//   clk     in  1  clock
//   reset   in  1  synchronous active-high reset
//   a_in    in  1  raw phase A (asynchronous)
//   b_in    in  1  raw phase B (asynchronous)
//   clr_err in  1  clears err; a same-cycle illegal transition wins
//   step    out 1  one-cycle pulse per legal phase transition
//   dir     out 1  1 = up (A leads B), 0 = down; holds last direction
//   err     out 1  sticky illegal-transition flag
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic clr_err,
  output logic step,
  output logic dir,
  output logic err
);

  logic       a_s, b_s;
  logic       a_f, b_f;
  logic [1:0] cur;
  logic [1:0] prev;
  logic [1:0] diff;

  phase_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .x_in  (a_in),
    .x_s   (a_s),
    .x_f   (a_f)
  );

  phase_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .x_in  (b_in),
    .x_s   (b_s),
    .x_f   (b_f)
  );

  assign cur  = {a_f, b_f};
  assign diff = cur ^ prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      // prev loads the same value the filters load, so release sees no change.
      prev <= {a_s, b_s};
      step <= 1'b0;
      dir  <= DIR_UP;
      err  <= 1'b0;
    end else begin
      prev <= cur;
      step <= 1'b0;
      if (diff == 2'b11) begin
        // Both phases moved: direction unknown; adopt the new phase as-is.
        err <= 1'b1;
      end else begin
        if (clr_err) begin
          err <= 1'b0;
        end
        if (cur == next_up(prev)) begin
          step <= 1'b1;
          dir  <= DIR_UP;
        end else if (diff != 2'b00) begin
          step <= 1'b1;
          dir  <= DIR_DN;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - scoreboard bench for quad_step_decoder
module tb_quad_step_decoder;

  localparam int NONE = 0;
  localparam int UP   = 1;
  localparam int DN   = 2;
  // Drive after posedge c: captured at c+1, step visible after posedge c+3+FILT_LEN.
  localparam int LAT  = 6;

  logic clk = 1'b0;
  logic reset, a_in, b_in, clr_err;
  logic step, dir, err;

  typedef struct {
    logic dir;
    int   cyc;
  } exp_t;

  exp_t       expq[$];
  int         cycle = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cnt4 = 4'd0;
  logic       cnt_clr = 1'b1;

  quad_step_decoder #(.FILT_LEN(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .clr_err (clr_err),
    .step    (step),
    .dir     (dir),
    .err     (err)
  );

  always #1 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Downstream up/down counter fed by step (enable) and dir (updn).
  always @(posedge clk) begin
    if (cnt_clr)   cnt4 <= 4'd0;
    else if (step) cnt4 <= dir ? cnt4 + 4'd1 : cnt4 - 4'd1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: every step pulse must match the oldest expected step.
  always @(negedge clk) begin
    exp_t e;
    if (step === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("step_dir", int'(dir), int'(e.dir));
        chk("step_cycle", cycle, e.cyc);
      end
    end
  end

  task automatic drive(input logic a, input logic b, input int kind);
    exp_t e;
    @(negedge clk);
    a_in = a;
    b_in = b;
    if (kind != NONE) begin
      e.dir = (kind == UP);
      e.cyc = cycle + LAT;
      expq.push_back(e);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; a_in = 1'b1; b_in = 1'b1; clr_err = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // 1: held 11 through reset and after: quiet outputs.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t1_err", int'(err), 0);
      chk("t1_dir", int'(dir), 1);
    end
    chk("t1_no_pending", expq.size(), 0);

    // Re-reset with inputs at 00.
    reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);

    // 2: up sequence.
    drive(1'b1, 1'b0, UP);
    drive(1'b1, 1'b1, UP);
    drive(1'b0, 1'b1, UP);
    drive(1'b0, 1'b0, UP);
    chk("t2_steps_seen", expq.size(), 0);
    chk("t2_counter", int'(cnt4), 4);
    chk("t2_dir", int'(dir), 1);

    // 3: down sequence.
    drive(1'b0, 1'b1, DN);
    drive(1'b1, 1'b1, DN);
    drive(1'b1, 1'b0, DN);
    drive(1'b0, 1'b0, DN);
    chk("t3_steps_seen", expq.size(), 0);
    chk("t3_counter", int'(cnt4), 0);
    chk("t3_dir", int'(dir), 0);

    // 4: 2-cycle glitch rejected, 3-cycle level accepted.
    @(negedge clk); a_in = 1'b1;
    repeat (2) @(negedge clk); a_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_glitch_dir", int'(dir), 0);
    drive(1'b1, 1'b0, UP);
    chk("t4_steps_seen", expq.size(), 0);
    chk("t4_dir", int'(dir), 1);

    // 5: illegal transitions and err clearing.
    drive(1'b0, 1'b0, DN);
    drive(1'b1, 1'b1, NONE);
    chk("t5_err_set", int'(err), 1);
    chk("t5_dir_hold", int'(dir), 0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("t5_err_clr", int'(err), 0);
    @(negedge clk); a_in = 1'b0; b_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_err_before", int'(err), 0);
    clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("t5_set_wins", int'(err), 1);
    repeat (5) @(negedge clk);
    chk("t5_steps_seen", expq.size(), 0);

    // 6: reset while a step is pending.
    @(negedge clk); a_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_step", int'(step), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_dir", int'(dir), 1);
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_err_after", int'(err), 0);
    chk("t6_dir_after", int'(dir), 1);
    chk("final_no_pending", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
